// File: rtl/bus_arbiter_if.sv
// Bus-ownership handshake between the round-robin arbiter and the tristate bus drivers.
// The arbiter side uses the master modport; requesters/drivers use the slave modport.
interface bus_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned OWNER_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   done;
    logic [N_REQ-1:0]   grant;
    logic [OWNER_W-1:0] owner;
    logic               busy;
    logic               timeout;

    modport master (
        input  req,
        input  done,
        output grant,
        output owner,
        output busy,
        output timeout
    );

    modport slave (
        output req,
        output done,
        input  grant,
        input  owner,
        input  busy,
        input  timeout
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin drive-enable arbiter for the shared tristate bus, with a dead turnaround cycle
// between owners. Define BUS_ARB_TIMEOUT_EN to build the MAX_HOLD hold limit and timeout pulse.
module bus_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic          clock,
    input  logic          reset,
    bus_arbiter_if.master bus
);
    localparam int unsigned OWNER_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 16 || MAX_HOLD < 1) begin : g_bad_param
        $error("bus_arbiter: N_REQ must be 2..16 and MAX_HOLD at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [N_REQ-1:0]   grant_r;
    logic [N_REQ-1:0]   grant_nxt;
    logic [OWNER_W-1:0] owner_r;
    logic [OWNER_W-1:0] owner_nxt;
    logic [OWNER_W-1:0] ptr_r;
    logic [OWNER_W-1:0] ptr_nxt;
    logic               busy_r;

    logic               pick_vld_c;
    logic [OWNER_W-1:0] pick_idx_c;
    logic [OWNER_W-1:0] scan_idx_c;
    logic               release_norm_c;
    logic               release_c;
    logic               hold_hit_c;

    // First requester after the last owner, wrapping; the last owner is checked last.
    always_comb begin
        pick_vld_c = 1'b0;
        pick_idx_c = '0;
        scan_idx_c = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            scan_idx_c = OWNER_W'((32'(ptr_r) + k) % N_REQ);
            if (!pick_vld_c && bus.req[scan_idx_c]) begin
                pick_vld_c = 1'b1;
                pick_idx_c = scan_idx_c;
            end
        end
    end

    assign release_norm_c = !bus.req[owner_r] || bus.done[owner_r];
    assign release_c      = release_norm_c || hold_hit_c;

    // State register and registered bus enables.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grant_r <= '0;
            owner_r <= '0;
            ptr_r   <= OWNER_W'(N_REQ - 1);
            busy_r  <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant_r <= grant_nxt;
            owner_r <= owner_nxt;
            ptr_r   <= ptr_nxt;
            busy_r  <= |grant_nxt;
        end
    end

    // Next-state logic; TURN arbitrates exactly like IDLE after its single dead cycle.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_r;
        owner_nxt = owner_r;
        ptr_nxt   = ptr_r;
        case (state)
            IDLE, TURN: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                if (pick_vld_c) begin
                    state_nxt = GRANT;
                    grant_nxt = N_REQ'(1) << pick_idx_c;
                    owner_nxt = pick_idx_c;
                    ptr_nxt   = pick_idx_c;
                end
            end
            GRANT: begin
                if (release_c) begin
                    state_nxt = TURN;
                    grant_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_r;
    logic [HOLD_W-1:0] hold_nxt;
    logic              timeout_r;

    // hold_r counts completed grant cycles; the edge ending cycle MAX_HOLD forces release.
    assign hold_hit_c = (hold_r == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        hold_nxt = hold_r;
        if (state != GRANT) begin
            hold_nxt = '0;
        end else if (!release_c) begin
            hold_nxt = hold_r + HOLD_W'(1);
        end
    end

    // Timeout pulses only when the hold limit alone ended the grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_r    <= '0;
            timeout_r <= 1'b0;
        end else begin
            hold_r    <= hold_nxt;
            timeout_r <= (state == GRANT) && hold_hit_c && !release_norm_c;
        end
    end

    assign bus.timeout = timeout_r;
`else
    assign hold_hit_c  = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.grant = grant_r;
    assign bus.owner = owner_r;
    assign bus.busy  = busy_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic against a
// behavioural round-robin model. Follows BUS_ARB_TIMEOUT_EN to pick the expected hold behaviour.
module tb_bus_arbiter;
    localparam int unsigned N        = 4;
    localparam int unsigned MAX_HOLD = 8;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    bus_arbiter_if #(.N_REQ(N)) bus ();

    bus_arbiter #(
        .N_REQ   (N),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Model: who holds the bus, for how many completed cycles, and who had it last.
    bit m_held;
    int m_owner;
    int m_ptr;
    int m_len;
    bit m_to;

    task automatic model_reset();
        m_held  = 1'b0;
        m_owner = 0;
        m_ptr   = N - 1;
        m_len   = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] d);
        bit rel;
        m_to = 1'b0;
        if (m_held) begin
            m_len++;
            rel = !r[m_owner] || d[m_owner];
            if (rel || (TO_EN && m_len >= MAX_HOLD)) begin
                m_held = 1'b0;
                m_to   = !rel;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (r[idx]) begin
                    m_held  = 1'b1;
                    m_owner = idx;
                    m_ptr   = idx;
                    m_len   = 0;
                    break;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [15:0] eg;
        eg = m_held ? (16'd1 << m_owner) : 16'd0;
        check({tag, ".grant"},   16'(bus.grant), eg);
        check({tag, ".owner"},   16'(bus.owner), 16'(m_owner));
        check({tag, ".busy"},    16'(bus.busy), 16'(m_held));
        check({tag, ".timeout"}, 16'(bus.timeout), 16'(m_to));
        check({tag, ".onehot"},  16'($countones(bus.grant) <= 1), 16'd1);
    endtask

    // One clock: model follows the inputs sampled at the edge, outputs checked 1 time unit later.
    task automatic cyc(input string tag);
        logic [N-1:0] r;
        logic [N-1:0] d;
        @(posedge clock);
        r = bus.req;
        d = bus.done;
        if (reset) model_reset();
        else model_edge(r, d);
        #1;
        check_model(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        bus.req  = 4'b1111;
        bus.done = 4'b0000;
        #1;
        check("rst_grant", 16'(bus.grant), 16'h0);
        cyc("rst_hold");
        cyc("rst_hold");
        #3 reset = 1'b0;
        cyc("rst_first");
        check("first_grant", 16'(bus.grant), 16'h1);
        check("first_owner", 16'(bus.owner), 16'h0);
        check("first_busy",  16'(bus.busy),  16'h1);

        // Rotation: every owner releases with done on its 2nd grant cycle.
        for (int o = 0; o < 4; o++) begin
            bus.done = 4'b0000;
            cyc("rot");
            check("rot_hold", 16'(bus.grant), 16'(1 << o));
            bus.done = 4'(1 << o);
            cyc("rot");
            check("rot_dead", 16'(bus.grant), 16'h0);
            bus.done = 4'b0000;
            cyc("rot");
            check("rot_next", 16'(bus.grant), 16'(1 << ((o + 1) % 4)));
        end

        // Single requester re-granted after every turnaround.
        bus.req = 4'b0100;
        cyc("single");
        cyc("single");
        check("single_enter", 16'(bus.grant), 16'h4);
        for (int rep = 0; rep < 3; rep++) begin
            cyc("single");
            check("single_c2", 16'(bus.grant), 16'h4);
            cyc("single");
            check("single_c3", 16'(bus.grant), 16'h4);
            bus.done = 4'b0100;
            cyc("single");
            check("single_dead", 16'(bus.grant), 16'h0);
            bus.done = 4'b0000;
            cyc("single");
            check("single_again", 16'(bus.grant), 16'h4);
        end

        // Non-owner done and req activity leave owner 1 alone.
        bus.req = 4'b0010;
        cyc("noise");
        cyc("noise");
        check("noise_enter", 16'(bus.grant), 16'h2);
        for (int i = 0; i < 6; i++) begin
            bus.done = 4'b1101;
            bus.req  = (i % 2 == 0) ? 4'b1010 : 4'b0010;
            cyc("noise");
            check("noise_hold", 16'(bus.grant), 16'h2);
        end
        bus.done = 4'b0000;
        bus.req  = 4'b0000;
        cyc("noise_rel");
        cyc("idle");
        check("idle_busy", 16'(bus.busy), 16'h0);

        // Hold limit: owner 0 with requester 1 waiting.
        bus.req = 4'b0011;
        cyc("hold");
        check("hold_enter", 16'(bus.grant), 16'h1);
        if (TO_EN) begin
            for (int i = 1; i < MAX_HOLD; i++) begin
                cyc("hold");
                check("hold_keep", 16'(bus.grant), 16'h1);
            end
            cyc("hold");
            check("hold_cut", 16'(bus.grant), 16'h0);
            check("hold_timeout", 16'(bus.timeout), 16'h1);
            cyc("hold");
            check("hold_next", 16'(bus.grant), 16'h2);
            check("hold_to_clr", 16'(bus.timeout), 16'h0);
        end else begin
            for (int i = 0; i < 120; i++) begin
                cyc("hold");
                check("hold_forever", 16'(bus.grant), 16'h1);
            end
        end

        // Asynchronous reset while requester 2 owns the bus.
        bus.req = 4'b0100;
        cyc("pre_rst");
        cyc("pre_rst");
        check("pre_rst_grant", 16'(bus.grant), 16'h4);
        #3 reset = 1'b1;
        #1;
        check("async_grant",   16'(bus.grant),   16'h0);
        check("async_busy",    16'(bus.busy),    16'h0);
        check("async_timeout", 16'(bus.timeout), 16'h0);
        model_reset();
        bus.req = 4'b1111;
        cyc("in_rst");
        #3 reset = 1'b0;
        cyc("post_rst");
        check("post_rst_grant", 16'(bus.grant), 16'h1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) bus.req = 4'($urandom);
            bus.done = 4'($urandom & $urandom & $urandom);
            cyc("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
